// File: rtl/gb_apu_pkg.sv
// Shared APU register-block definitions: NRx offsets, read-back OR masks and
// field bit positions used by the channel register front ends.
package gb_apu_pkg;

  typedef enum logic [2:0] {
    NR10 = 3'd0,
    NR11 = 3'd1,
    NR12 = 3'd2,
    NR13 = 3'd3,
    NR14 = 3'd4
  } nrx_e;

  localparam int unsigned NRX_COUNT = 5;

  // Bits that always read back as 1 (unused or write-only)
  localparam logic [7:0] NR10_RMASK     = 8'h80;
  localparam logic [7:0] NR11_RMASK     = 8'h3F;
  localparam logic [7:0] NR12_RMASK     = 8'h00;
  localparam logic [7:0] NR13_RMASK     = 8'hFF;
  localparam logic [7:0] NR14_RMASK     = 8'hBF;
  localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

  localparam int unsigned NR10_NEGATE_BIT  = 3;
  localparam int unsigned NR12_ENV_ADD_BIT = 3;
  localparam int unsigned NR14_TRIGGER_BIT = 7;
  localparam int unsigned NR14_LEN_EN_BIT  = 6;

endpackage

// File: rtl/pulse1_regs.sv
// Channel-1 pulse register file (NR10-NR14): CPU byte access, field outputs,
// and one-cycle trigger / length-load strobes toward the pulse channel.
module pulse1_regs
  import gb_apu_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apu_enable,
  input  logic [7:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic [2:0]  sweep_period,
  output logic        negate,
  output logic [2:0]  shift,
  output logic [1:0]  duty_cycle,
  output logic [5:0]  length_load,
  output logic        length_write,
  output logic [3:0]  starting_volume,
  output logic        env_add,
  output logic [2:0]  period,
  output logic        dac_enable,
  output logic [10:0] freq,
  output logic        length_enable,
  output logic        trigger
);

  logic [6:0] r_nr10;
  logic [7:0] r_nr11;
  logic [7:0] r_nr12;
  logic [7:0] r_nr13;
  logic       r_nr14_len_en;
  logic [2:0] r_nr14_freq_hi;
  logic       r_trigger;
  logic       r_length_write;
  logic [7:0] r_rdata;
  logic       r_rvalid;

  logic [7:0] w_off;
  logic       w_in_range;
  nrx_e       w_reg;
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic [7:0] w_read_val;

  // Offset subtraction wraps, so addresses below BASE_ADDR land out of range
  assign w_off      = addr - BASE_ADDR;
  assign w_in_range = (w_off < 8'(NRX_COUNT));
  assign w_reg      = nrx_e'(w_off[2:0]);
  assign w_wr_acc   = wr_en & apu_enable & w_in_range;
  assign w_rd_acc   = rd_en & ~wr_en;

  always_comb begin
    w_read_val = UNMAPPED_RDATA;
    if (w_in_range) begin
      case (w_reg)
        NR10:    w_read_val = {1'b0, r_nr10} | NR10_RMASK;
        NR11:    w_read_val = r_nr11 | NR11_RMASK;
        NR12:    w_read_val = r_nr12 | NR12_RMASK;
        NR13:    w_read_val = NR13_RMASK;
        NR14:    w_read_val = {1'b0, r_nr14_len_en, 6'b0} | NR14_RMASK;
        default: w_read_val = UNMAPPED_RDATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nr10         <= '0;
      r_nr11         <= '0;
      r_nr12         <= '0;
      r_nr13         <= '0;
      r_nr14_len_en  <= 1'b0;
      r_nr14_freq_hi <= '0;
      r_trigger      <= 1'b0;
      r_length_write <= 1'b0;
      r_rdata        <= '0;
      r_rvalid       <= 1'b0;
    end else begin
      r_trigger      <= w_wr_acc && (w_reg == NR14) && wdata[NR14_TRIGGER_BIT];
      r_length_write <= w_wr_acc && (w_reg == NR11);

      if (!apu_enable) begin
        r_nr10         <= '0;
        r_nr11         <= '0;
        r_nr12         <= '0;
        r_nr13         <= '0;
        r_nr14_len_en  <= 1'b0;
        r_nr14_freq_hi <= '0;
      end else if (w_wr_acc) begin
        case (w_reg)
          NR10: r_nr10 <= wdata[6:0];
          NR11: r_nr11 <= wdata;
          NR12: r_nr12 <= wdata;
          NR13: r_nr13 <= wdata;
          NR14: begin
            r_nr14_len_en  <= wdata[NR14_LEN_EN_BIT];
            r_nr14_freq_hi <= wdata[2:0];
          end
          default: ;
        endcase
      end

      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= w_read_val;
    end
  end

  assign rdata           = r_rdata;
  assign rvalid          = r_rvalid;
  assign sweep_period    = r_nr10[6:4];
  assign negate          = r_nr10[NR10_NEGATE_BIT];
  assign shift           = r_nr10[2:0];
  assign duty_cycle      = r_nr11[7:6];
  assign length_load     = r_nr11[5:0];
  assign length_write    = r_length_write;
  assign starting_volume = r_nr12[7:4];
  assign env_add         = r_nr12[NR12_ENV_ADD_BIT];
  assign period          = r_nr12[2:0];
  assign dac_enable      = |r_nr12[7:3];
  assign freq            = {r_nr14_freq_hi, r_nr13};
  assign length_enable   = r_nr14_len_en;
  assign trigger         = r_trigger;

endmodule

// File: tb/tb_pulse1_regs.sv
// Scoreboard bench for pulse1_regs: byte-level register model drives expected
// per-cycle outputs and read responses into queues checked by a monitor.
module tb_pulse1_regs;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        apu_enable = 1'b0;
  logic [7:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [2:0]  sweep_period;
  logic        negate;
  logic [2:0]  shift;
  logic [1:0]  duty_cycle;
  logic [5:0]  length_load;
  logic        length_write;
  logic [3:0]  starting_volume;
  logic        env_add;
  logic [2:0]  period;
  logic        dac_enable;
  logic [10:0] freq;
  logic        length_enable;
  logic        trigger;

  always #5 clk = ~clk;

  pulse1_regs #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .apu_enable(apu_enable), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .sweep_period(sweep_period), .negate(negate), .shift(shift),
    .duty_cycle(duty_cycle), .length_load(length_load), .length_write(length_write),
    .starting_volume(starting_volume), .env_add(env_add), .period(period),
    .dac_enable(dac_enable), .freq(freq), .length_enable(length_enable),
    .trigger(trigger)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Behavioural model: five byte registers, with per-register stored-bit and read-OR masks
  int unsigned nr[5];
  bit [7:0] keep_mask[5] = '{8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h47};
  bit [7:0] read_mask[5] = '{8'h80, 8'h3F, 8'h00, 8'hFF, 8'hBF};
  bit [7:0] m_rdata = 8'h00;

  typedef struct {
    bit        trig;
    bit        lw;
    bit        rv;
    bit [7:0]  rd;
    bit [35:0] cfg;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] rd_q[$];

  function automatic bit [35:0] model_cfg();
    int unsigned fq;
    fq = (nr[4] % 8) * 256 + nr[3];
    return {3'((nr[0] / 16) % 8), 1'((nr[0] / 8) % 2), 3'(nr[0] % 8),
            2'(nr[1] / 64), 6'(nr[1] % 64),
            4'(nr[2] / 16), 1'((nr[2] / 8) % 2), 3'(nr[2] % 8), 1'(nr[2] >= 8),
            11'(fq), 1'((nr[4] / 64) % 2)};
  endfunction

  function automatic bit [35:0] dut_cfg();
    return {sweep_period, negate, shift, duty_cycle, length_load,
            starting_volume, env_add, period, dac_enable, freq, length_enable};
  endfunction

  task automatic step(input bit rst, input bit apu, input bit [7:0] a,
                      input bit w, input bit r, input bit [7:0] d);
    exp_t e;
    int   idx;
    bit   inr, acc;
    @(negedge clk);
    reset = rst; apu_enable = apu; addr = a; wr_en = w; rd_en = r; wdata = d;
    idx = int'(a) - int'(BASE);
    inr = (idx >= 0) && (idx < 5);
    e.trig = 0; e.lw = 0; e.rv = 0;
    if (rst) begin
      for (int i = 0; i < 5; i++) nr[i] = 0;
      m_rdata = 8'h00;
    end else begin
      acc = w && apu && inr;
      e.trig = acc && (idx == 4) && d[7];
      e.lw   = acc && (idx == 1);
      if (r && !w) begin
        e.rv    = 1;
        m_rdata = inr ? (8'(nr[idx]) | read_mask[idx]) : 8'hFF;
        rd_q.push_back(m_rdata);
      end
      if (!apu) for (int i = 0; i < 5; i++) nr[i] = 0;
      else if (acc) nr[idx] = int'(d & keep_mask[idx]);
    end
    e.rd  = m_rdata;
    e.cfg = model_cfg();
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit apu);
    step(0, apu, 8'h00, 0, 0, 8'h00);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rvalid", 64'(rvalid), 64'(e.rv));
      chk("trigger", 64'(trigger), 64'(e.trig));
      chk("length_write", 64'(length_write), 64'(e.lw));
      chk("rdata_hold", 64'(rdata), 64'(e.rd));
      chk("cfg", 64'(dut_cfg()), 64'(e.cfg));
    end
    if (rvalid === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 64'(rvalid), 64'd0);
      else chk("rd_resp", 64'(rdata), 64'(rd_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] rst_rd[5] = '{8'h80, 8'h3F, 8'h00, 8'hFF, 8'hBF};

    step(1, 0, 8'h00, 0, 0, 8'h00);
    step(1, 0, 8'h00, 0, 0, 8'h00);
    idle(1);
    chk("reset_freq", 64'(freq), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'h00);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, BASE + 8'(i), 0, 1, 8'h00);
      idle(1);
      chk("reset_read_rvalid", 64'(rvalid), 64'd1);
      chk("reset_read", 64'(rdata), 64'(rst_rd[i]));
    end

    step(0, 1, BASE + 8'd0, 1, 0, 8'h2B);
    step(0, 1, BASE + 8'd1, 1, 0, 8'h52);
    step(0, 1, BASE + 8'd2, 1, 0, 8'hF2);
    chk("lw_after_nr11", 64'(length_write), 64'd1);
    step(0, 1, BASE + 8'd3, 1, 0, 8'h00);
    chk("lw_one_cycle", 64'(length_write), 64'd0);
    step(0, 1, BASE + 8'd4, 1, 0, 8'hC4);
    chk("trig_not_early", 64'(trigger), 64'd0);
    idle(1);
    chk("trigger_pulse", 64'(trigger), 64'd1);
    chk("sweep_period", 64'(sweep_period), 64'd2);
    chk("negate", 64'(negate), 64'd1);
    chk("shift", 64'(shift), 64'd3);
    chk("duty_cycle", 64'(duty_cycle), 64'd1);
    chk("length_load", 64'(length_load), 64'd18);
    chk("starting_volume", 64'(starting_volume), 64'd15);
    chk("env_add", 64'(env_add), 64'd0);
    chk("period", 64'(period), 64'd2);
    chk("freq", 64'(freq), 64'd1024);
    chk("length_enable", 64'(length_enable), 64'd1);
    chk("dac_enable", 64'(dac_enable), 64'd1);
    idle(1);
    chk("trigger_one_cycle", 64'(trigger), 64'd0);

    step(0, 1, BASE + 8'd4, 1, 0, 8'h45);
    idle(1);
    chk("notrig_trigger", 64'(trigger), 64'd0);
    chk("notrig_freq", 64'(freq), 64'd1280);
    step(0, 1, BASE + 8'd4, 0, 1, 8'h00);
    idle(1);
    chk("nr14_readback", 64'(rdata), 64'hFF);

    idle(0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, BASE + 8'(i), 0, 1, 8'h00);
      idle(0);
      chk("apuoff_read", 64'(rdata), 64'(rst_rd[i]));
    end
    step(0, 0, BASE + 8'd2, 1, 0, 8'hF0);
    idle(0);
    chk("apuoff_dac", 64'(dac_enable), 64'd0);
    step(0, 1, BASE + 8'd2, 1, 0, 8'hF0);
    idle(1);
    chk("apuon_dac", 64'(dac_enable), 64'd1);

    step(0, 1, BASE + 8'd1, 1, 1, 8'h8A);
    idle(1);
    chk("wr_rd_rvalid", 64'(rvalid), 64'd0);
    chk("wr_rd_duty", 64'(duty_cycle), 64'd2);
    step(0, 1, BASE + 8'd1, 0, 1, 8'h00);
    idle(1);
    chk("wr_rd_readback", 64'(rdata), 64'hBF);

    step(0, 1, BASE + 8'd5, 1, 0, 8'h77);
    step(0, 1, BASE + 8'd5, 0, 1, 8'h00);
    idle(1);
    chk("oor_read", 64'(rdata), 64'hFF);

    step(0, 1, BASE + 8'd4, 1, 0, 8'h87);
    step(1, 1, 8'h00, 0, 0, 8'h00);
    chk("pre_reset_trigger", 64'(trigger), 64'd1);
    idle(1);
    chk("reset_kills_trigger", 64'(trigger), 64'd0);
    chk("reset_clears_freq", 64'(freq), 64'd0);
    chk("reset_clears_dac", 64'(dac_enable), 64'd0);

    step(0, 1, BASE + 8'd4, 1, 0, 8'h81);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("apufall_trigger", 64'(trigger), 64'd1);
    chk("apufall_freq_held", 64'(freq), 64'h100);
    idle(1);
    chk("apufall_trigger_done", 64'(trigger), 64'd0);
    chk("apufall_freq_clear", 64'(freq), 64'd0);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) != 0,
           BASE - 8'd1 + 8'($urandom_range(0, 6)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           8'($urandom));
    end

    idle(1);
    idle(1);
    @(negedge clk);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse1_regs.md
# pulse1_regs

Register-file front end for the channel-1 pulse generator: decodes CPU byte writes/reads to NR10–NR14 (0xFF10–0xFF14), holds the register contents, and drives the pulse channel's configuration ports. It also generates the single-cycle trigger and length-load strobes. It sits directly upstream of `pulseChannel1`, between the CPU bus and the channel.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h10: low byte of the NR10 address; NR10..NR14 occupy BASE_ADDR..BASE_ADDR+4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `apu_enable`  in  1  NR52 bit 7; low = APU powered off.
- `addr`  in  8  low byte of CPU address (high byte 0xFF decoded externally).
- `wr_en`  in  1  write strobe, one cycle per byte.
- `rd_en`  in  1  read strobe, one cycle per byte.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, valid when `rvalid`.
- `rvalid`  out  1  read response strobe.
- `sweep_period`  out  3  NR10[6:4].
- `negate`  out  1  NR10[3].
- `shift`  out  3  NR10[2:0].
- `duty_cycle`  out  2  NR11[7:6].
- `length_load`  out  6  NR11[5:0].
- `length_write`  out  1  one-cycle pulse on any accepted NR11 write.
- `starting_volume`  out  4  NR12[7:4].
- `env_add`  out  1  NR12[3].
- `period`  out  3  NR12[2:0].
- `dac_enable`  out  1  NR12[7:3] != 0.
- `freq`  out  11  {NR14[2:0], NR13[7:0]}.
- `length_enable`  out  1  NR14[6].
- `trigger`  out  1  one-cycle pulse on an accepted NR14 write with wdata[7]=1.

## Operation
- Storage: NR10[6:0], NR11[7:0], NR12[7:0], NR13[7:0], NR14 bits 6 and 2:0. NR14 bit 7 is not stored.
- Accepted write: `wr_en` && `apu_enable` && addr in range. Register updates at that edge.
- Ignored write: out-of-range address, or `apu_enable`=0. No state change and no strobes.
- Strobes:
  - `trigger` and `length_write` are registered and high for exactly the one cycle after the accepting edge.
  - Back-to-back accepted writes produce back-to-back pulses.
  - A trigger write updates `freq[10:8]` and `length_enable` in the same cycle that `trigger` rises, so the channel samples the new values.
- Reads: `rd_en` with `wr_en`=0 sets `rvalid`=1 next cycle with masked data:
  - NR10 = reg|0x80
  - NR11 = reg|0x3F
  - NR12 = reg
  - NR13 = 0xFF (write-only)
  - NR14 = reg|0xBF
  - out-of-range = 0xFF
  - Reads are allowed while `apu_enable`=0.
- Simultaneous `wr_en`+`rd_en`: the write is processed, the read is dropped, and `rvalid` stays 0.
- APU power-off: while `apu_enable`=0, all stored registers are held at 0 synchronously each cycle and both strobes are forced low.
- Reset: all registers 0, all outputs 0, `rdata`=0x00, `rvalid`=0.

## Timing
- Write-to-output latency: 1 cycle. The field outputs are direct register outputs.
- Read latency: 1 cycle. `rdata` holds its last value when `rvalid`=0.
- Strobe width: exactly 1 clk.
- `reset` mid-pulse: the strobe clears at that same edge.
- `apu_enable` falling in the cycle after a trigger write: the registered `trigger` pulse still completes; registers clear at the following edge.
- Reset overrides `apu_enable` and all bus activity.

## Structure
- Shared package `gb_apu_pkg` holds:
  - NRx register offset constants (NR10..NR14, shared with other channel register blocks).
  - Read-OR masks per register.
  - Field bit-position constants.
- Single module. The read mux is kept inline; no sub-module is warranted.

## Test plan
- Reset, then read each address 0x10–0x14 → rdata 0x80, 0x3F, 0x00, 0xFF, 0xBF, each with `rvalid` one cycle after `rd_en`.
- Write NR10=0x2B, NR11=0x52, NR12=0xF2, NR13=0x00, NR14=0xC4 →
  - outputs: sweep_period=2, negate=1, shift=3, duty_cycle=1, length_load=18, starting_volume=15, env_add=0, period=2, freq=1024, length_enable=1, dac_enable=1;
  - strobes: `trigger` high exactly 1 cycle after the NR14 write; `length_write` high 1 cycle after the NR11 write.
- NR14 write with bit 7=0 → freq/length_enable update, `trigger` stays 0; readback returns 0xBF|0x40=0xFF.
- `apu_enable`=0 → all registers read back as their masks; a write of NR12=0xF0 is ignored and `dac_enable` stays 0. Raise `apu_enable` and repeat the write → `dac_enable`=1.
- Same-cycle `wr_en`+`rd_en` to NR11 → register updated, `rvalid`=0. Writes to address 0x15 → no effect; reading 0x15 returns 0xFF.
- Assert `reset` the cycle after a trigger write → `trigger` low at that edge and all outputs 0 the following cycle.
